// File: rtl/scan_scheduler.sv
// Row/digit scan scheduler for an 8x8 bicolour matrix and a six-digit LED display,
// with a double-buffered frame store whose swap is deferred to the next frame boundary.
module scan_scheduler #(
    parameter int ROW_CYCLES   = 8192,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_r,
    input  logic [7:0]  wr_g,
    input  logic        swap_req,
    output logic        swap_ack,
    input  logic [23:0] digits,
    output logic        frame_start,
    output logic [7:0]  led_segout,
    output logic [2:0]  led_scanout,
    output logic [7:0]  matrix_segout_r,
    output logic [7:0]  matrix_segout_g,
    output logic [7:0]  matrix_scanout,
    output logic [1:0]  dbg_swap_state
);

    localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

    // Write handshake: a row write is accepted on the rising edge where wr_valid && wr_ready.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } swap_state_t;

    swap_state_t   state, state_next;
    logic [CW-1:0] cyc;
    logic [2:0]    row;
    logic          sel;
    logic [7:0]    buf_r [2][8];
    logic [7:0]    buf_g [2][8];
    logic [3:0]    digit_hold;
    logic [3:0]    live_digit;
    logic [3:0]    cur_digit;
    logic          row_wrap;
    logic          frame_wrap;
    logic          blank;
    logic          first_vis;

    assign row_wrap   = (cyc == CW'(ROW_CYCLES - 1));
    assign frame_wrap = row_wrap && (row == 3'd7);
    assign blank      = (cyc < CW'(BLANK_CYCLES));
    assign first_vis  = (cyc == CW'(BLANK_CYCLES));
    assign dbg_swap_state = state;

    function automatic logic [7:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 8'hFC;
            4'd1:    seg_pattern = 8'h60;
            4'd2:    seg_pattern = 8'hDA;
            4'd3:    seg_pattern = 8'hF2;
            4'd4:    seg_pattern = 8'h66;
            4'd5:    seg_pattern = 8'hB6;
            4'd6:    seg_pattern = 8'hBE;
            4'd7:    seg_pattern = 8'hE0;
            4'd8:    seg_pattern = 8'hFE;
            4'd9:    seg_pattern = 8'hF6;
            default: seg_pattern = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
            row <= 3'd0;
        end else if (row_wrap) begin
            cyc <= '0;
            row <= row + 3'd1;
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Gating with reset keeps the handshake closed and swallows a pending ack during reset.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        swap_ack   = 1'b0;
        case (state)
            RUN: begin
                wr_ready = !reset;
                if (swap_req) state_next = PEND;
            end
            PEND: begin
                if (frame_wrap) state_next = ACK;
            end
            ACK: begin
                swap_ack   = !reset;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // The front select only flips on the row 7 -> 0 edge, so a frame never mixes buffers.
    always_ff @(posedge clk) begin
        if (reset)                            sel <= 1'b0;
        else if (state == PEND && frame_wrap) sel <= ~sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    buf_r[b][i] <= 8'h00;
                    buf_g[b][i] <= 8'h00;
                end
            end
        end else if (wr_valid && wr_ready) begin
            buf_r[~sel][wr_row] <= wr_r;
            buf_g[~sel][wr_row] <= wr_g;
        end
    end

    always_comb begin
        live_digit = 4'd0;
        case (row)
            3'd0:    live_digit = digits[3:0];
            3'd1:    live_digit = digits[7:4];
            3'd2:    live_digit = digits[11:8];
            3'd3:    live_digit = digits[15:12];
            3'd4:    live_digit = digits[19:16];
            3'd5:    live_digit = digits[23:20];
            default: live_digit = 4'd0;
        endcase
    end

    // The digit is captured on the first visible cycle and frozen for the rest of the row.
    assign cur_digit = first_vis ? live_digit : digit_hold;

    always_ff @(posedge clk) begin
        if (reset)          digit_hold <= 4'd0;
        else if (first_vis) digit_hold <= live_digit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start     <= 1'b0;
            led_scanout     <= 3'd0;
            led_segout      <= 8'h00;
            matrix_scanout  <= 8'h00;
            matrix_segout_r <= 8'h00;
            matrix_segout_g <= 8'h00;
        end else begin
            frame_start <= frame_wrap;
            led_scanout <= (row < 3'd6) ? row : 3'd0;
            if (blank) begin
                led_segout      <= 8'h00;
                matrix_scanout  <= 8'h00;
                matrix_segout_r <= 8'h00;
                matrix_segout_g <= 8'h00;
            end else begin
                led_segout      <= (row < 3'd6) ? seg_pattern(cur_digit) : 8'h00;
                matrix_scanout  <= 8'h01 << row;
                matrix_segout_r <= buf_r[sel][row];
                matrix_segout_g <= buf_g[sel][row];
            end
        end
    end

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler with short rows (16 cycles, 2 blank) so whole
// frames of 128 cycles can be walked and checked against hand-computed values.
module tb_scan_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [7:0]  wr_r;
    logic [7:0]  wr_g;
    logic        swap_req;
    logic        swap_ack;
    logic [23:0] digits;
    logic        frame_start;
    logic [7:0]  led_segout;
    logic [2:0]  led_scanout;
    logic [7:0]  matrix_segout_r;
    logic [7:0]  matrix_segout_g;
    logic [7:0]  matrix_scanout;
    logic [1:0]  dbg_swap_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_exp [6] = '{8'h60, 8'hDA, 8'h00, 8'hFE, 8'hF6, 8'hFC};

    scan_scheduler #(.ROW_CYCLES(16), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
        .wr_r(wr_r), .wr_g(wr_g),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .digits(digits), .frame_start(frame_start),
        .led_segout(led_segout), .led_scanout(led_scanout),
        .matrix_segout_r(matrix_segout_r), .matrix_segout_g(matrix_segout_g),
        .matrix_scanout(matrix_scanout), .dbg_swap_state(dbg_swap_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_fs();
        int t;
        t = 0;
        while (frame_start !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        check_val("frame_start_timeout", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic check_row(input int r, input logic [7:0] er, input logic [7:0] eg);
        check_val($sformatf("row%0d_scan", r), {24'd0, matrix_scanout}, 32'h1 << r);
        check_val($sformatf("row%0d_r", r), {24'd0, matrix_segout_r}, {24'd0, er});
        check_val($sformatf("row%0d_g", r), {24'd0, matrix_segout_g}, {24'd0, eg});
    endtask

    initial begin
        int n;
        reset = 1'b1; wr_valid = 1'b0; wr_row = 3'd0; wr_r = 8'h00; wr_g = 8'h00;
        swap_req = 1'b0; digits = 24'h098F21;
        tick(3);
        check_val("rst_scan", {24'd0, matrix_scanout}, 32'h0);
        check_val("rst_seg", {24'd0, led_segout}, 32'h0);
        check_val("rst_fs", {31'd0, frame_start}, 32'h0);
        check_val("rst_ack", {31'd0, swap_ack}, 32'h0);
        check_val("rst_rdy", {31'd0, wr_ready}, 32'h0);
        reset = 1'b0;
        #1;
        check_val("rdy_after_rst", {31'd0, wr_ready}, 32'h1);

        // Idle frame: scan walk, blanking, LED digits, frame_start 128 cycles after reset.
        for (int k = 1; k <= 128; k++) begin
            int off;
            int r;
            tick(1);
            off = (k - 1) % 16;
            r   = (k - 1) / 16;
            check_val($sformatf("walk%0d_scan", k), {24'd0, matrix_scanout},
                      (off < 2) ? 32'h0 : (32'h1 << r));
            check_val($sformatf("walk%0d_r", k), {24'd0, matrix_segout_r}, 32'h0);
            check_val($sformatf("walk%0d_fs", k), {31'd0, frame_start}, (k == 128) ? 32'h1 : 32'h0);
            check_val($sformatf("walk%0d_lscan", k), {29'd0, led_scanout}, (r < 6) ? r : 0);
            check_val($sformatf("walk%0d_lseg", k), {24'd0, led_segout},
                      (off < 2 || r >= 6) ? 32'h0 : {24'd0, seg_exp[r]});
            check_val($sformatf("walk%0d_ack", k), {31'd0, swap_ack}, 32'h0);
        end

        // Write row 3 mid-frame, then request a swap.
        tick(20);
        wr_valid = 1'b1; wr_row = 3'd3; wr_r = 8'hA5; wr_g = 8'h0F;
        check_val("a_rdy", {31'd0, wr_ready}, 32'h1);
        tick(1);
        wr_valid = 1'b0; swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        check_val("a_pend_rdy", {31'd0, wr_ready}, 32'h0);
        check_val("a_pend_ack", {31'd0, swap_ack}, 32'h0);
        tick(31);
        check_row(3, 8'h00, 8'h00);
        check_val("a_pend_rdy2", {31'd0, wr_ready}, 32'h0);
        wait_fs();
        check_val("a_ack", {31'd0, swap_ack}, 32'h1);
        check_val("a_ack_rdy", {31'd0, wr_ready}, 32'h0);
        tick(1);
        check_val("a_ack_low", {31'd0, swap_ack}, 32'h0);
        check_val("a_run_rdy", {31'd0, wr_ready}, 32'h1);
        tick(50);
        check_row(3, 8'hA5, 8'h0F);

        // wr_valid held through PEND/ACK: accepted only in the first RUN cycle.
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        wr_valid = 1'b1; wr_row = 3'd5; wr_r = 8'h11; wr_g = 8'h22;
        check_val("b_pend_rdy", {31'd0, wr_ready}, 32'h0);
        wait_fs();
        check_val("b_ack", {31'd0, swap_ack}, 32'h1);
        check_val("b_ack_rdy", {31'd0, wr_ready}, 32'h0);
        tick(1);
        check_val("b_run_rdy", {31'd0, wr_ready}, 32'h1);
        tick(1);
        wr_valid = 1'b0;
        tick(81);
        check_row(5, 8'h00, 8'h00);

        // Write and swap request in the same RUN cycle.
        wr_valid = 1'b1; wr_row = 3'd6; wr_r = 8'hC3; wr_g = 8'h3C; swap_req = 1'b1;
        check_val("c_rdy", {31'd0, wr_ready}, 32'h1);
        tick(1);
        wr_valid = 1'b0; swap_req = 1'b0;
        check_val("c_pend_rdy", {31'd0, wr_ready}, 32'h0);
        tick(15);
        check_row(6, 8'h00, 8'h00);
        wait_fs();
        check_val("c_ack", {31'd0, swap_ack}, 32'h1);
        tick(51);
        check_row(3, 8'hA5, 8'h0F);
        tick(32);
        check_row(5, 8'h11, 8'h22);
        tick(16);
        check_row(6, 8'hC3, 8'h3C);

        // Reset while a swap is pending.
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        check_val("d_pend_rdy", {31'd0, wr_ready}, 32'h0);
        reset = 1'b1;
        tick(1);
        check_val("d_rst_scan", {24'd0, matrix_scanout}, 32'h0);
        check_val("d_rst_r", {24'd0, matrix_segout_r}, 32'h0);
        check_val("d_rst_lseg", {24'd0, led_segout}, 32'h0);
        check_val("d_rst_ack", {31'd0, swap_ack}, 32'h0);
        check_val("d_rst_rdy", {31'd0, wr_ready}, 32'h0);
        reset = 1'b0;
        #1;
        check_val("d_rdy_after", {31'd0, wr_ready}, 32'h1);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (swap_ack === 1'b1) check_val("d_stray_ack", 32'h1, 32'h0);
            if (frame_start === 1'b1) break;
        end
        check_val("d_first_fs", n, 32'd128);
        tick(51);
        check_row(3, 8'h00, 8'h00);
        check_val("d_run_rdy", {31'd0, wr_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
